run_monitor: RTL and testbench
==============================

# run_monitor

Parametrised, synthesizable run monitor for the RV32I core. It replaces hand-written testbench completion checks (poll a register for an expected value, stop at the last PC) with a single block that decides run outcome in hardware. It sits beside `cpu` and taps the register-file write port and the retiring PC. It supports several watched registers, an end-of-program PC, a cycle timeout, and cycle/retire counters. Benches and FPGA wrappers read its sticky verdict instead of peeking into `cpu.dp.regfile`.

## Interface
Parameters:
- XLEN, 32, data/PC width
- NUM_WATCH, 2, number of watched registers (1..8)
- RADDR_W, 5, register address width
- CYC_W, 32, width of cycle and retire counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; clears counters and shadows, enters RUN
- pc  in  XLEN  PC of the retiring instruction
- pc_valid  in  1  an instruction retires this cycle
- end_pc  in  XLEN  PC of the last program instruction
- timeout_limit  in  CYC_W  max RUN cycles; 0 disables the timeout
- rf_we  in  1  register-file write enable
- rf_waddr  in  RADDR_W  write address
- rf_wdata  in  XLEN  write data
- watch_en  in  NUM_WATCH  per-channel enable
- watch_addr  in  NUM_WATCH*RADDR_W  flattened; channel i at [i*RADDR_W +: RADDR_W]
- watch_expect  in  NUM_WATCH*XLEN  flattened expected values
- state  out  2  00 IDLE, 01 RUN, 10 DONE
- done  out  1  verdict valid (state==DONE)
- pass  out  1  all enabled channels matched
- fail  out  1  end_pc retired without pass
- timeout  out  1  timeout_limit reached
- match_mask  out  NUM_WATCH  per-channel current match (shadow==expect)
- cycle_count  out  CYC_W  cycles spent in RUN
- retired_count  out  CYC_W  pc_valid pulses in RUN

## Operation
- Reset (rst=0, asynchronous): state=IDLE. done, pass, fail, and timeout are 0. Both counters are 0. All shadows are 0. match_mask reflects the zero shadows.
- IDLE: ignores all traffic except start.
- start, from any state: clears the counters, shadows, and verdict bits, then goes to RUN.
- RUN, each edge:
  - cycle_count increments.
  - retired_count increments if pc_valid.
  - Each channel i with rf_we=1, rf_waddr==watch_addr[i], and rf_waddr!=0 loads rf_wdata into shadow[i].
  - A channel watching x0 keeps its shadow at 0.
- match_mask[i] = (shadow[i]==watch_expect[i]). This is combinational from the registered shadow.
- Exit conditions, evaluated at each RUN edge on registered values:
  - P: watch_en != 0 and (match_mask | ~watch_en) is all-ones.
  - F: pc_valid and pc==end_pc.
  - T: timeout_limit != 0 and cycle_count+1 == timeout_limit.
- Priority is P > F > T. Exactly one verdict bit is set, and state becomes DONE.
- DONE: verdict bits, counters, and shadows freeze. They are sticky until start or reset.
- With watch_en==0, the run ends only by F or T. Pass is never set.
- Counters saturate at all-ones and do not wrap.
- Several channels may watch the same register. Each updates independently.

## Timing
- The shadow updates on the edge that samples the write. match_mask is valid after that edge.
- The verdict registers one edge after the completing write. The latency from the write edge to done=1 is exactly 1 cycle.
- F is detected on the edge sampling pc_valid with pc==end_pc. done is high after that edge.
  - If the final write and end_pc retire in the same sample, the shadow is not yet updated, so F wins.
  - Drivers must therefore retire end_pc as the instruction after the final write.
- T: with timeout_limit=N, done rises after the N-th RUN edge, and cycle_count=N.
- start in the same cycle as a completion condition: start wins. The monitor restarts and no verdict is set.
- Reset asserted mid-RUN: all outputs go immediately (asynchronously) to their reset values.

## Test plan
- Square test:
  - Setup: channel0 watch x10, expect 49, enabled; end_pc=432; timeout 0.
  - Stimulus: after start, write x10=7, then x10=49.
  - Required: match_mask[0] rises after the 49 write, then pass=1, done=1, fail=0 one cycle later.
- End without pass:
  - Setup: expect x10=49.
  - Stimulus: only write 48, then pc_valid with pc=432.
  - Required: fail=1, pass=0; retired_count equals the number of pc_valid pulses.
- Timeout:
  - Setup: timeout_limit=20; no writes, no end_pc.
  - Required: done and timeout rise after the 20th RUN edge; cycle_count=20; the state stays frozen for the next 10 cycles.
- Two channels:
  - Setup: watch x10=49 and x11=5, both enabled.
  - Stimulus: write x11=5; wait 3 cycles; write x10=49.
  - Required: no pass after the first write; pass after the second write.
  - Re-run with watch_en=01: pass occurs after the x10 write alone.
- x0 and restart:
  - Stimulus: a watch on x0 expecting 0 gives an immediate pass on the first RUN edge. Writes to x0 with data 5 leave the shadow at 0.
  - Required: pulsing start in DONE clears the counters and verdict, and state returns to RUN.
- Reset mid-run:
  - Stimulus: assert rst low between clock edges during RUN.
  - Required: state=IDLE and the counters read 0 before the next edge.

Source files
------------

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run outcome monitor: watched-register shadows, end-PC and timeout verdicts
module run_monitor #(
  parameter int XLEN      = 32,
  parameter int NUM_WATCH = 2,
  parameter int RADDR_W   = 5,
  parameter int CYC_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [XLEN-1:0]                pc,
  input  logic                           pc_valid,
  input  logic [XLEN-1:0]                end_pc,
  input  logic [CYC_W-1:0]               timeout_limit,
  input  logic                           rf_we,
  input  logic [RADDR_W-1:0]             rf_waddr,
  input  logic [XLEN-1:0]                rf_wdata,
  input  logic [NUM_WATCH-1:0]           watch_en,
  input  logic [NUM_WATCH*RADDR_W-1:0]   watch_addr,
  input  logic [NUM_WATCH*XLEN-1:0]      watch_expect,
  output logic [1:0]                     state,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [NUM_WATCH-1:0]           match_mask,
  output logic [CYC_W-1:0]               cycle_count,
  output logic [CYC_W-1:0]               retired_count
);

  localparam logic [1:0]       S_IDLE  = 2'b00;
  localparam logic [1:0]       S_RUN   = 2'b01;
  localparam logic [1:0]       S_DONE  = 2'b10;
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W:0]   CYC_ONE_W = {{CYC_W{1'b0}}, 1'b1};

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [XLEN-1:0] shadow [NUM_WATCH];
  logic            hit_pass;
  logic            hit_fail;
  logic            hit_time;
  logic [CYC_W:0]  cyc_next_w;

  // Exit conditions look at registered shadows, so a write only counts one edge later.
  always_comb begin
    cyc_next_w = {1'b0, cycle_count} + CYC_ONE_W;
    hit_pass   = (watch_en != '0) && (&(match_mask | ~watch_en));
    hit_fail   = pc_valid && (pc == end_pc);
    hit_time   = (timeout_limit != '0) && (cyc_next_w == {1'b0, timeout_limit});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (hit_pass || hit_fail || hit_time) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state      = state_q;
    done       = (state_q == S_DONE);
    match_mask = '0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      match_mask[i] = (shadow[i] == watch_expect[i*XLEN +: XLEN]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
      for (int i = 0; i < NUM_WATCH; i++) shadow[i] <= '0;
    end else if (start) begin
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
      for (int i = 0; i < NUM_WATCH; i++) shadow[i] <= '0;
    end else if (state_q == S_RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CYC_ONE;
      if (pc_valid && (retired_count != '1)) retired_count <= retired_count + CYC_ONE;
      // x0 is never loaded, so a channel watching it stays at zero.
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (rf_we && (rf_waddr != '0) && (rf_waddr == watch_addr[i*RADDR_W +: RADDR_W])) begin
          shadow[i] <= rf_wdata;
        end
      end
      pass    <= hit_pass;
      fail    <= !hit_pass && hit_fail;
      timeout <= !hit_pass && !hit_fail && hit_time;
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - directed and randomized checks of run_monitor against a behavioural model
module tb_run_monitor;

  localparam int XLEN = 32;
  localparam int NW   = 2;
  localparam int RW   = 5;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] end_pc;
  logic [CW-1:0]   timeout_limit;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NW-1:0]   watch_en;
  logic [NW*RW-1:0]   watch_addr;
  logic [NW*XLEN-1:0] watch_expect;
  logic [1:0]      state;
  logic            done, pass, fail, timeout;
  logic [NW-1:0]   match_mask;
  logic [CW-1:0]   cycle_count, retired_count;

  run_monitor #(.XLEN(XLEN), .NUM_WATCH(NW), .RADDR_W(RW), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid), .end_pc(end_pc),
    .timeout_limit(timeout_limit), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .watch_en(watch_en), .watch_addr(watch_addr), .watch_expect(watch_expect),
    .state(state), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_mask(match_mask), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model: 0 idle, 1 running, 2 finished
  int          m_phase;
  int          m_cyc, m_ret;
  logic [31:0] m_shadow [NW];
  logic        m_pass, m_fail, m_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] exp_mask();
    logic [NW-1:0] mm;
    for (int i = 0; i < NW; i++) mm[i] = (m_shadow[i] == watch_expect[i*XLEN +: XLEN]);
    return mm;
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_ret = 0; m_pass = 0; m_fail = 0; m_to = 0;
    for (int i = 0; i < NW; i++) m_shadow[i] = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_phase = 0;
  endtask

  task automatic model_step();
    logic p, f, t;
    if (start) begin
      model_clear();
      m_phase = 1;
    end else if (m_phase == 1) begin
      p = (watch_en != 0) && ((exp_mask() | ~watch_en) == {NW{1'b1}});
      f = pc_valid && (pc == end_pc);
      t = (timeout_limit != 0) && (m_cyc + 1 == int'(timeout_limit));
      if (m_cyc < CMAX) m_cyc++;
      if (pc_valid && m_ret < CMAX) m_ret++;
      for (int i = 0; i < NW; i++)
        if (rf_we && rf_waddr != 0 && rf_waddr == watch_addr[i*RW +: RW]) m_shadow[i] = rf_wdata;
      if (p) m_pass = 1;
      else if (f) m_fail = 1;
      else if (t) m_to = 1;
      if (p || f || t) m_phase = 2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(m_phase));
    chk({tag, "_done"}, 64'(done), 64'(m_phase == 2));
    chk({tag, "_pass"}, 64'(pass), 64'(m_pass));
    chk({tag, "_fail"}, 64'(fail), 64'(m_fail));
    chk({tag, "_timeout"}, 64'(timeout), 64'(m_to));
    chk({tag, "_mask"}, 64'(match_mask), 64'(exp_mask()));
    chk({tag, "_cyc"}, 64'(cycle_count), 64'(m_cyc));
    chk({tag, "_ret"}, 64'(retired_count), 64'(m_ret));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wr(input int a, input int d);
    rf_we = 1'b1; rf_waddr = RW'(a); rf_wdata = XLEN'(d);
  endtask

  task automatic do_start(input string tag);
    rf_we = 1'b0; pc_valid = 1'b0; start = 1'b1;
    step(tag);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pc = '0; pc_valid = 1'b0; end_pc = 32'd432;
    timeout_limit = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    watch_en = 2'b01; watch_addr = {5'd0, 5'd10}; watch_expect = {32'd0, 32'd49};
    model_reset();
    #12;
    check_all("reset");
    #5 rst = 1'b1;

    wr(10, 49); pc_valid = 1'b1; pc = 32'd432;
    step("idle_ignore");
    pc_valid = 1'b0; rf_we = 1'b0;

    // square test
    do_start("sq_start");
    wr(10, 7);  step("sq_w7");
    wr(10, 49); step("sq_w49");
    chk("sq_mm_rise", 64'(match_mask[0]), 64'd1);
    chk("sq_not_done_yet", 64'(done), 64'd0);
    rf_we = 1'b0; step("sq_verdict");
    chk("sq_pass", 64'(pass), 64'd1);
    chk("sq_fail", 64'(fail), 64'd0);
    wr(10, 3); step("sq_frozen");
    rf_we = 1'b0;

    // end without pass
    do_start("end_start");
    wr(10, 48); step("end_w48");
    rf_we = 1'b0; pc_valid = 1'b1;
    pc = 32'd400; step("end_pc400");
    pc = 32'd404; step("end_pc404");
    pc = 32'd432; step("end_pc432");
    pc_valid = 1'b0;
    chk("end_fail", 64'(fail), 64'd1);
    chk("end_ret", 64'(retired_count), 64'd3);

    // timeout
    timeout_limit = 8'd20;
    do_start("to_start");
    repeat (19) step("to_run");
    chk("to_not_yet", 64'(done), 64'd0);
    step("to_edge20");
    chk("to_flag", 64'(timeout), 64'd1);
    chk("to_cyc", 64'(cycle_count), 64'd20);
    repeat (10) step("to_frozen");
    chk("to_cyc_frozen", 64'(cycle_count), 64'd20);
    timeout_limit = '0;

    // two channels
    watch_addr = {5'd11, 5'd10}; watch_expect = {32'd5, 32'd49}; watch_en = 2'b11;
    do_start("two_start");
    wr(11, 5); step("two_w11");
    rf_we = 1'b0;
    repeat (3) step("two_wait");
    chk("two_no_pass", 64'(pass), 64'd0);
    wr(10, 49); step("two_w10");
    rf_we = 1'b0; step("two_verdict");
    chk("two_pass", 64'(pass), 64'd1);
    watch_en = 2'b01;
    do_start("one_start");
    wr(10, 49); step("one_w10");
    rf_we = 1'b0; step("one_verdict");
    chk("one_pass", 64'(pass), 64'd1);

    // x0 watch, write to x0, then restart from DONE
    watch_addr = {5'd0, 5'd0}; watch_expect = {32'd5, 32'd0}; watch_en = 2'b01;
    do_start("x0_start");
    wr(0, 5); step("x0_first_edge");
    rf_we = 1'b0;
    chk("x0_pass", 64'(pass), 64'd1);
    chk("x0_mask", 64'(match_mask), 64'd1);
    do_start("x0_restart");
    chk("x0_restart_state", 64'(state), 64'd1);
    chk("x0_restart_cyc", 64'(cycle_count), 64'd0);

    // start coincident with a completing condition
    watch_addr = {5'd0, 5'd10}; watch_expect = {32'd0, 32'd49};
    do_start("sw_start");
    wr(10, 49); step("sw_w49");
    rf_we = 1'b0; pc_valid = 1'b1; pc = 32'd432; start = 1'b1;
    step("sw_collide");
    start = 1'b0; pc_valid = 1'b0;
    chk("sw_no_verdict", 64'(done), 64'd0);

    // asynchronous reset mid-run
    do_start("rm_start");
    pc_valid = 1'b1; pc = 32'd8;
    repeat (3) step("rm_run");
    pc_valid = 1'b0;
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("rm_async");
    chk("rm_cyc_zero", 64'(cycle_count), 64'd0);
    @(posedge clk); #3 rst = 1'b1;

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      watch_addr    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      watch_expect  = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
      watch_en      = 2'($urandom_range(0, 3));
      end_pc        = 32'($urandom_range(1, 4) * 4);
      timeout_limit = 8'($urandom_range(0, 40));
      do_start("rnd_start");
      for (int c = 0; c < 60 && m_phase != 2; c++) begin
        rf_we    = ($urandom_range(0, 2) != 0);
        rf_waddr = 5'($urandom_range(0, 3));
        rf_wdata = 32'($urandom_range(0, 3));
        pc_valid = ($urandom_range(0, 1) != 0);
        pc       = ($urandom_range(0, 9) == 0) ? end_pc : 32'(64 + 4 * $urandom_range(0, 7));
        start    = ($urandom_range(0, 49) == 0);
        step("rnd");
        start = 1'b0;
      end
      rf_we = 1'b0; pc_valid = 1'b0;
      step("rnd_tail");
    end

    // counter saturation
    watch_en = 2'b00; timeout_limit = '0; end_pc = 32'd432;
    do_start("sat_start");
    pc_valid = 1'b1; pc = 32'd0;
    repeat (300) step("sat");
    pc_valid = 1'b0;
    chk("sat_cyc", 64'(cycle_count), 64'd255);
    chk("sat_ret", 64'(retired_count), 64'd255);
    chk("sat_no_pass", 64'(pass), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
